// File: rtl/soc_ram_pkg.sv
// soc_ram_pkg: shared constants and helpers for the soc_ram_dp dual-port RAM.
//   RD_LAT_MIN/RD_LAT_MAX : legal READ_LATENCY range, checked at elaboration
//   MAX_DATA_W            : widest word the byteenable-merge helper handles
//   byte_lanes()          : number of byte lanes in a word of a given width
//   be_merge()            : replace the byteenable-selected lanes of a word
package soc_ram_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int MAX_DATA_W = 1024;

    function automatic int byte_lanes(input int w);
        return w / 8;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0]   old_w,
        input logic [MAX_DATA_W-1:0]   new_w,
        input logic [MAX_DATA_W/8-1:0] be
    );
        logic [MAX_DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_DATA_W / 8; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/soc_ram_rd_pipe.sv
// soc_ram_rd_pipe: per-port read pipeline (stage 1, optional stage 2) with clken hold.
//   clk, reset_n : clock, asynchronous active-low reset
//   clken        : 0 freezes every stage and masks rvalid
//   req, din     : accepted read and the word to return for it
//   rdata, rvalid: read data and its valid pulse, READ_LATENCY cycles after req
module soc_ram_rd_pipe #(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              req,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

    logic              v1;
    logic [DATA_W-1:0] d1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (clken) begin
            v1 <= req;
            if (req) d1 <= din;
        end
    end

    // A held result stays in its stage while clken is low and is shown again
    // once clken returns, so masking rvalid avoids both loss and duplication.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              v2;
            logic [DATA_W-1:0] d2;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else if (clken) begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end
            assign rdata  = d2;
            assign rvalid = v2 & clken;
        end else begin : g_lat1
            assign rdata  = d1;
            assign rvalid = v1 & clken;
        end
    endgenerate

endmodule

// File: rtl/soc_ram_dp.sv
// soc_ram_dp: dual-port Avalon-MM RAM; port A read-only fetch, port B read/write with byteenable.
//   clk, reset_n, clken          : clock, async active-low reset, global stall (0 = stall)
//   a_address/a_read             : port A request; a_waitrequest/a_readdata/a_readdatavalid
//   b_address/b_read/b_write/
//   b_byteenable/b_writedata     : port B request; b_waitrequest/b_readdata/b_readdatavalid
//   range_err                    : sticky flag for any accepted access at address >= DEPTH
// Build option: define RAM_BYPASS_EN to forward a same-cycle port B write into a port A read.
module soc_ram_dp
    import soc_ram_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 1024,
    parameter int    ADDR_W       = $clog2(DEPTH),
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "soc_ram_dp.hex"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic                  a_read,
    output logic                  a_waitrequest,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic                  b_waitrequest,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    output logic                  range_err
);

    localparam int  BE_W   = byte_lanes(DATA_W);
    localparam bit  LAT_OK = READ_LATENCY >= RD_LAT_MIN && READ_LATENCY <= RD_LAT_MAX;

    generate
        if (!LAT_OK) begin : g_bad_lat
            $error("soc_ram_dp: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0]   wo, wn, r;
        logic [MAX_DATA_W/8-1:0] wb;
        wo = '0;
        wn = '0;
        wb = '0;
        wo[DATA_W-1:0] = old_w;
        wn[DATA_W-1:0] = new_w;
        wb[BE_W-1:0]   = be;
        r = be_merge(wo, wn, wb);
        return r[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic              a_acc, b_rd, b_wr, a_oor, b_oor;
    logic [DATA_W-1:0] a_mem, b_mem, a_din, b_wword;

    assign a_waitrequest = ~clken;
    assign b_waitrequest = ~clken;

    // A simultaneous read+write on port B is a master error: the write wins.
    assign a_acc = a_read & clken;
    assign b_wr  = b_write & clken;
    assign b_rd  = b_read & ~b_write & clken;

    assign a_oor = 32'(a_address) >= DEPTH;
    assign b_oor = 32'(b_address) >= DEPTH;

    assign a_mem   = a_oor ? '0 : mem[a_address];
    assign b_mem   = b_oor ? '0 : mem[b_address];
    assign b_wword = merge(b_mem, b_writedata, b_byteenable);

`ifdef RAM_BYPASS_EN
    assign a_din = (b_wr && !b_oor && b_address == a_address)
                 ? merge(a_mem, b_writedata, b_byteenable) : a_mem;
`else
    assign a_din = a_mem;
`endif

    always_ff @(posedge clk) begin
        if (b_wr && !b_oor) mem[b_address] <= b_wword;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) range_err <= 1'b0;
        else if ((a_acc && a_oor) || ((b_wr || b_rd) && b_oor)) range_err <= 1'b1;
    end

    soc_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
        .clk    (clk),
        .reset_n(reset_n),
        .clken  (clken),
        .req    (a_acc),
        .din    (a_din),
        .rdata  (a_readdata),
        .rvalid (a_readdatavalid)
    );

    soc_ram_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
        .clk    (clk),
        .reset_n(reset_n),
        .clken  (clken),
        .req    (b_rd),
        .din    (b_mem),
        .rdata  (b_readdata),
        .rvalid (b_readdatavalid)
    );

endmodule

// File: tb/tb_soc_ram_dp.sv
// tb_soc_ram_dp: scoreboard bench for soc_ram_dp (DEPTH 1000, latency 2).
module tb_soc_ram_dp;

    localparam int DW    = 32;
    localparam int DEPTH = 1000;
    localparam int AW    = $clog2(DEPTH);
    localparam int LAT   = 2;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          clken = 1'b1;
    logic [AW-1:0] a_address = '0;
    logic          a_read = 1'b0;
    logic          a_waitrequest;
    logic [DW-1:0] a_readdata;
    logic          a_readdatavalid;
    logic [AW-1:0] b_address = '0;
    logic          b_read = 1'b0;
    logic          b_write = 1'b0;
    logic [3:0]    b_byteenable = '0;
    logic [DW-1:0] b_writedata = '0;
    logic          b_waitrequest;
    logic [DW-1:0] b_readdata;
    logic          b_readdatavalid;
    logic          range_err;

    soc_ram_dp #(
        .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .a_address(a_address), .a_read(a_read), .a_waitrequest(a_waitrequest),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int            cnt = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            skew_from = 0;
    int            skew_by = 0;
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] model [DEPTH];

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cnt);
        end
    endtask

    function automatic logic [DW-1:0] bmerge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                             input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic int due_of();
        int d;
        d = cnt + LAT;
        if (skew_by > 0 && d >= skew_from) d += skew_by;
        return d;
    endfunction

    // one bus cycle: drive, predict, advance to just after the next rising edge
    task automatic step(input logic ar, input int aa, input logic br, input logic bw,
                        input int ba, input logic [3:0] be, input logic [DW-1:0] wd);
        exp_t e;
        a_read = ar;  a_address = AW'(aa);
        b_read = br;  b_write = bw;  b_address = AW'(ba);
        b_byteenable = be;  b_writedata = wd;  clken = 1'b1;
        if (ar) begin
            e.data = aa < DEPTH ? model[aa] : '0;
`ifdef RAM_BYPASS_EN
            if (bw && ba == aa && aa < DEPTH) e.data = bmerge(e.data, wd, be);
`endif
            e.due = due_of();
            qa.push_back(e);
        end
        if (br && !bw) begin
            e.data = ba < DEPTH ? model[ba] : '0;
            e.due  = due_of();
            qb.push_back(e);
        end
        if (bw && ba < DEPTH) model[ba] = bmerge(model[ba], wd, be);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0, 4'h0, '0); endtask
    task automatic rd_a(input int a); step(1, a, 0, 0, 0, 4'h0, '0); endtask
    task automatic rd_b(input int a); step(0, 0, 1, 0, a, 4'h0, '0); endtask
    task automatic wr_b(input int a, input logic [3:0] be, input logic [DW-1:0] d);
        step(0, 0, 0, 1, a, be, d);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_readdatavalid) begin
            if (qa.size() == 0) chk("a_extra_valid", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_data", a_readdata, e.data);
                chk("a_latency", DW'(cnt), DW'(e.due));
            end
        end else if (qa.size() != 0 && qa[0].due == cnt) chk("a_missing_valid", 0, 1);
        if (b_readdatavalid) begin
            if (qb.size() == 0) chk("b_extra_valid", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_data", b_readdata, e.data);
                chk("b_latency", DW'(cnt), DW'(e.due));
            end
        end else if (qb.size() != 0 && qb[0].due == cnt) chk("b_missing_valid", 0, 1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_a_rdata", a_readdata, '0);
        chk("rst_a_valid", DW'(a_readdatavalid), 0);
        chk("rst_b_rdata", b_readdata, '0);
        chk("rst_b_valid", DW'(b_readdatavalid), 0);
        chk("rst_range_err", DW'(range_err), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH; i++) wr_b(i, 4'hF, $urandom);

        // byte-lane write, then fetch over A and read-after-write over B
        wr_b(5, 4'hF, 32'hDEADBEEF);
        wr_b(5, 4'h2, 32'h0000AA00);
        rd_a(5);
        chk("model_5", model[5], 32'hDEADAAEF);
        rd_b(5);
        wr_b(30, 4'hC, 32'hCAFE0000);
        rd_b(30);

        // A/B same-address collisions, full and partial byteenable
        wr_b(7, 4'hF, 32'h0);
        step(1, 7, 0, 1, 7, 4'hF, 32'h12345678);
        rd_a(7);
        wr_b(9, 4'hF, 32'hAABBCCDD);
        step(1, 9, 0, 1, 9, 4'h5, 32'h11223344);
        rd_a(9);
        idle();

        // back-to-back reads, then a three-cycle stall
        c = cnt;
        skew_from = c + 4;
        skew_by = 3;
        for (int i = 0; i < 4; i++) rd_a(i);
        for (int i = 0; i < 3; i++) begin
            a_read = 1'b0;
            clken = 1'b0;
            #1;
            chk("stall_a_wait", DW'(a_waitrequest), 1);
            chk("stall_b_wait", DW'(b_waitrequest), 1);
            chk("stall_a_valid", DW'(a_readdatavalid), 0);
            @(posedge clk);
            #1;
        end
        repeat (4) idle();
        skew_by = 0;
        chk("stall_drain", DW'(qa.size()), 0);

        // read+write together on B: write done, no read result, no range error
        step(0, 0, 1, 1, 20, 4'hF, 32'h5A5AA5A5);
        rd_b(20);
        idle();
        chk("proto_range_err", DW'(range_err), 0);

        // out-of-range accesses
        rd_a(1010);
        chk("oor_range_err", DW'(range_err), 1);
        rd_b(1010);
        wr_b(1010, 4'hF, 32'hFFFFFFFF);
        for (int i = 0; i < DEPTH; i++) rd_a(i);
        repeat (4) idle();
        chk("oor_sticky", DW'(range_err), 1);
        chk("drain_a", DW'(qa.size()), 0);
        chk("drain_b", DW'(qb.size()), 0);

        // reset while a read is in flight
        rd_a(5);
        reset_n = 1'b0;
        qa.delete();
        #1;
        chk("mid_rst_a_rdata", a_readdata, '0);
        chk("mid_rst_a_valid", DW'(a_readdatavalid), 0);
        chk("mid_rst_b_rdata", b_readdata, '0);
        chk("mid_rst_range_err", DW'(range_err), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) idle();
        rd_a(5);
        repeat (4) idle();
        chk("final_drain", DW'(qa.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
